fsm_cnt_arbiter: RTL and testbench
==================================

// Module: fsm_cnt_arbiter
// PURPOSE
//  Shares one saturating event counter (CNT_W bits, parity and all-ones flags) between N_REQ requesters.
//  Round-robin arbiter grants exclusive sessions. Only the owner's event line drives the counter.
//  At session end the final count is reported with a one-cycle done pulse.
//  Sits between requesting agents and any logic that consumes the parity/saturation flags.
// PARAMETERS
//  N_REQ   4   number of requesters (>=2)
//  CNT_W   2   counter width; saturates at all-ones
//  TIMEOUT 8   consecutive idle ACTIVE cycles before forced release (>=2; only with FSM_ARB_TIMEOUT_EN)
//  OWN_W   = $clog2(N_REQ), localparam
// PORTS
//  clk      in   1      clock, rising edge
//  reset_n  in   1      asynchronous, active-low reset
//  req      in   N_REQ  session request, one bit per requester, level
//  rel      in   N_REQ  release; only the owner's bit is honoured
//  x        in   N_REQ  event input; only the owner's bit is counted
//  gnt      out  N_REQ  one-hot grant, registered
//  owner    out  OWN_W  index of current/last owner
//  busy     out  1      high in ACTIVE and RELEASE
//  cnt      out  CNT_W  live counter value
//  z_odd    out  1      ^cnt (combinational from cnt register)
//  z_sat    out  1      &cnt (combinational from cnt register)
//  done     out  1      one-cycle pulse at session end
//  res_cnt  out  CNT_W  final count of last session, held until next done
//  res_to   out  1      last session ended by timeout, held until next done
// BEHAVIOUR
//  Reset: state=IDLE. gnt, owner, busy, cnt, done, res_cnt and res_to are all 0. RR pointer ptr=0. Idle timer=0.
//  States: IDLE -> ACTIVE -> RELEASE -> IDLE. No other states. Encodings are illegal-safe: any other encoding -> IDLE.
//  IDLE, cycle t:
//   - If req!=0, pick the first set bit searching ptr, ptr+1, ... modulo N_REQ.
//   - At t+1: ACTIVE, gnt=onehot(winner), owner=winner, cnt=0, timer=0.
//  ACTIVE:
//   - x[owner]=1 and cnt!=all-ones -> cnt+1. At all-ones, cnt holds (no wrap).
//   - Non-owner x/rel bits and all req bits are ignored. Dropping req[owner] does not end the session.
//  rel[owner]=1 at cycle t:
//   - At t+1: RELEASE, gnt=0, done=1, res_cnt=cnt including any x counted at t, res_to=0.
//  Simultaneous x[owner] and rel[owner]: the event is counted, then the session is released.
//  RELEASE (one cycle):
//   - ptr=(owner+1) mod N_REQ. At the next cycle: IDLE, done=0. cnt holds its final value until the next grant.
//   - Back-to-back sessions have at least 1 IDLE cycle between RELEASE and the next grant.
//  Reset mid-session: all state is cleared immediately (asynchronous). No done pulse. res_* cleared.
// CONFIGURATION
//  FSM_ARB_TIMEOUT_EN defined:
//   - Timer counts ACTIVE cycles with x[owner]=0 and clears on x[owner]=1.
//   - On the TIMEOUT-th consecutive idle cycle with rel[owner]=0: enter RELEASE with res_to=1.
//   - If rel[owner] and the timeout fall in the same cycle, rel wins (res_to=0).
//  FSM_ARB_TIMEOUT_EN undefined:
//   - No timer logic. A session ends only on rel[owner]. res_to is tied 0.
// TESTING
//  1 req=0001 held, then 3 x[0] pulses, then rel[0] -> gnt=0001 one cycle after req.
//    (cnt,z_odd,z_sat) = (1,1,0), (2,1,0), (3,0,1). done pulses once with res_cnt=3, res_to=0.
//  2 Owner 2, then 5 x[2] pulses -> cnt saturates at 3 with z_sat=1 held. After rel[2], res_cnt=3.
//  3 req=1111 held, each owner asserts rel on its first ACTIVE cycle.
//    -> grant order 0001, 0010, 0100, 1000, 0001; 3 cycles per session.
//  4 Owner 0, x=0010 and rel=0010 pulsed -> cnt stays 0, gnt stays 0001, no done.
//  5 Timeout build, owner 1, no x for 8 cycles -> done, res_to=1, res_cnt=0.
//    Same stimulus in a build without the macro -> stays ACTIVE, no done.
//  6 Owner 3 with cnt=2, then reset_n=0 mid-cycle -> gnt=0 and cnt=0 immediately.
//    After release of reset, req=1111 -> gnt=0001 (ptr=0).

Source files
------------

// File: rtl/fsm_cnt_arbiter.sv
// Round-robin arbiter that lends one saturating event counter to N_REQ agents.
// Optional forced release on idle sessions: define FSM_ARB_TIMEOUT_EN.
module fsm_cnt_arbiter #(
   parameter int N_REQ   = 4,
   parameter int CNT_W   = 2,
   parameter int TIMEOUT = 8
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N_REQ-1:0]         req,
   input  logic [N_REQ-1:0]         rel,
   input  logic [N_REQ-1:0]         x,
   output logic [N_REQ-1:0]         gnt,
   output logic [$clog2(N_REQ)-1:0] owner,
   output logic                     busy,
   output logic [CNT_W-1:0]         cnt,
   output logic                     z_odd,
   output logic                     z_sat,
   output logic                     done,
   output logic [CNT_W-1:0]         res_cnt,
   output logic                     res_to
);

   localparam int OWN_W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACTIVE  = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t             state, state_n;
   logic [N_REQ-1:0]   gnt_n;
   logic [OWN_W-1:0]   owner_n, ptr, ptr_n;
   logic [OWN_W-1:0]   win, cand;
   logic               found;
   logic [CNT_W-1:0]   cnt_n, res_cnt_n;
   logic               done_n;
   logic               x_own, rel_own;

`ifdef FSM_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer, timer_n;
   logic          res_to_q, res_to_n;

   assign res_to = res_to_q;
`else
   assign res_to = 1'b0;
`endif

   assign x_own   = x[owner];
   assign rel_own = rel[owner];
   assign busy    = (state == ACTIVE) || (state == RELEASE);
   assign z_odd   = ^cnt;
   assign z_sat   = &cnt;

   // first requester at or after the round-robin pointer
   always_comb begin
      found = 1'b0;
      win   = '0;
      cand  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand = OWN_W'((int'(ptr) + i) % N_REQ);
         if (!found && req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      state_n   = state;
      gnt_n     = gnt;
      owner_n   = owner;
      cnt_n     = cnt;
      done_n    = 1'b0;
      res_cnt_n = res_cnt;
      ptr_n     = ptr;
`ifdef FSM_ARB_TIMEOUT_EN
      timer_n   = timer;
      res_to_n  = res_to_q;
`endif
      unique case (state)
         IDLE: begin
            if (found) begin
               state_n      = ACTIVE;
               gnt_n        = '0;
               gnt_n[win]   = 1'b1;
               owner_n      = win;
               cnt_n        = '0;
`ifdef FSM_ARB_TIMEOUT_EN
               timer_n      = '0;
`endif
            end
         end
         ACTIVE: begin
            if (x_own && !z_sat)
               cnt_n = cnt + 1'b1;
`ifdef FSM_ARB_TIMEOUT_EN
            timer_n = x_own ? '0 : timer + 1'b1;
`endif
            if (rel_own) begin
               state_n   = RELEASE;
               gnt_n     = '0;
               done_n    = 1'b1;
               res_cnt_n = cnt_n;
`ifdef FSM_ARB_TIMEOUT_EN
               res_to_n  = 1'b0;
            end else if (!x_own && timer == TW'(TIMEOUT - 1)) begin
               state_n   = RELEASE;
               gnt_n     = '0;
               done_n    = 1'b1;
               res_cnt_n = cnt_n;
               res_to_n  = 1'b1;
`endif
            end
         end
         RELEASE: begin
            state_n = IDLE;
            ptr_n   = (owner == OWN_W'(N_REQ - 1)) ? '0 : owner + 1'b1;
         end
         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         gnt     <= '0;
         owner   <= '0;
         cnt     <= '0;
         done    <= 1'b0;
         res_cnt <= '0;
         ptr     <= '0;
      end else begin
         state   <= state_n;
         gnt     <= gnt_n;
         owner   <= owner_n;
         cnt     <= cnt_n;
         done    <= done_n;
         res_cnt <= res_cnt_n;
         ptr     <= ptr_n;
      end
   end

`ifdef FSM_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timer    <= '0;
         res_to_q <= 1'b0;
      end else begin
         timer    <= timer_n;
         res_to_q <= res_to_n;
      end
   end
`endif

endmodule

// File: tb/tb_fsm_cnt_arbiter.sv
// Directed vector bench for fsm_cnt_arbiter (N_REQ=4, CNT_W=2, TIMEOUT=8).
// Vector table plus hand-written reset sequences.
module tb_fsm_cnt_arbiter;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] req, rel, x;
   logic [3:0] gnt;
   logic [1:0] owner;
   logic       busy;
   logic [1:0] cnt;
   logic       z_odd, z_sat, done;
   logic [1:0] res_cnt;
   logic       res_to;

   int total = 0;
   int bad   = 0;

   fsm_cnt_arbiter #(.N_REQ(4), .CNT_W(2), .TIMEOUT(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (req),
      .rel     (rel),
      .x       (x),
      .gnt     (gnt),
      .owner   (owner),
      .busy    (busy),
      .cnt     (cnt),
      .z_odd   (z_odd),
      .z_sat   (z_sat),
      .done    (done),
      .res_cnt (res_cnt),
      .res_to  (res_to)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req, rel, x;
      logic [3:0] gnt;
      logic [1:0] own, cnt;
      logic       odd, sat, done, busy;
      logic [1:0] rc;
      logic       rt;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(
      logic [3:0] rq, logic [3:0] rl, logic [3:0] xx,
      logic [3:0] g, logic [1:0] o, logic [1:0] c,
      logic od, logic st, logic dn, logic bs,
      logic [1:0] rc, logic rt);
      vec_t r;
      r.req = rq; r.rel = rl; r.x = xx;
      r.gnt = g; r.own = o; r.cnt = c;
      r.odd = od; r.sat = st; r.done = dn; r.busy = bs;
      r.rc = rc; r.rt = rt;
      return r;
   endfunction

   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   initial begin
      // test 3: full rotation from ptr=0, 3 cycles per session
      tbl.push_back(v(4'hF, 4'h0, 4'h0, 4'h1, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(v(4'hF, 4'h1, 4'h0, 4'h0, 0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(v(4'hF, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(4'hF, 4'h0, 4'h0, 4'h2, 1, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(v(4'hF, 4'h2, 4'h0, 4'h0, 1, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(v(4'hF, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(4'hF, 4'h0, 4'h0, 4'h4, 2, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(v(4'hF, 4'h4, 4'h0, 4'h0, 2, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(v(4'hF, 4'h0, 4'h0, 4'h0, 2, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(4'hF, 4'h0, 4'h0, 4'h8, 3, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(v(4'hF, 4'h8, 4'h0, 4'h0, 3, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(v(4'hF, 4'h0, 4'h0, 4'h0, 3, 0, 0, 0, 0, 0, 0, 0));
      tbl.push_back(v(4'hF, 4'h0, 4'h0, 4'h1, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(v(4'h0, 4'h1, 4'h0, 4'h0, 0, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0, 0));
      // test 1: owner 0 (ptr=1 wraps), three events, req dropped mid-session
      tbl.push_back(v(4'h1, 4'h0, 4'h0, 4'h1, 0, 0, 0, 0, 0, 1, 0, 0));
      tbl.push_back(v(4'h1, 4'h0, 4'h1, 4'h1, 0, 1, 1, 0, 0, 1, 0, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h1, 4'h1, 0, 2, 1, 0, 0, 1, 0, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h1, 4'h1, 0, 3, 0, 1, 0, 1, 0, 0));
      tbl.push_back(v(4'h0, 4'h1, 4'h0, 4'h0, 0, 3, 0, 1, 1, 1, 3, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h0, 0, 3, 0, 1, 0, 0, 3, 0));
      // test 2: owner 2, saturation
      tbl.push_back(v(4'h4, 4'h0, 4'h0, 4'h4, 2, 0, 0, 0, 0, 1, 3, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h4, 4'h4, 2, 1, 1, 0, 0, 1, 3, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h4, 4'h4, 2, 2, 1, 0, 0, 1, 3, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h4, 4'h4, 2, 3, 0, 1, 0, 1, 3, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h4, 4'h4, 2, 3, 0, 1, 0, 1, 3, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h4, 4'h4, 2, 3, 0, 1, 0, 1, 3, 0));
      tbl.push_back(v(4'h0, 4'h4, 4'h0, 4'h0, 2, 3, 0, 1, 1, 1, 3, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h0, 2, 3, 0, 1, 0, 0, 3, 0));
      // test 4: owner 0, foreign x/rel ignored, then x+rel together
      tbl.push_back(v(4'h1, 4'h0, 4'h0, 4'h1, 0, 0, 0, 0, 0, 1, 3, 0));
      tbl.push_back(v(4'h0, 4'h2, 4'h2, 4'h1, 0, 0, 0, 0, 0, 1, 3, 0));
      tbl.push_back(v(4'h0, 4'h2, 4'h2, 4'h1, 0, 0, 0, 0, 0, 1, 3, 0));
      tbl.push_back(v(4'h0, 4'h1, 4'h1, 4'h0, 0, 1, 1, 0, 1, 1, 1, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h0, 0, 1, 1, 0, 0, 0, 1, 0));
      // test 5: owner 1 idles for 8 active cycles
      tbl.push_back(v(4'h2, 4'h0, 4'h0, 4'h2, 1, 0, 0, 0, 0, 1, 1, 0));
      for (int i = 0; i < 7; i++)
         tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h2, 1, 0, 0, 0, 0, 1, 1, 0));
`ifdef FSM_ARB_TIMEOUT_EN
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 1, 1, 0, 1));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(4'h0, 4'h2, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 1));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 1));
`else
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h2, 1, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h2, 1, 0, 0, 0, 0, 1, 1, 0));
      tbl.push_back(v(4'h0, 4'h2, 4'h0, 4'h0, 1, 0, 0, 0, 1, 1, 0, 0));
      tbl.push_back(v(4'h0, 4'h0, 4'h0, 4'h0, 1, 0, 0, 0, 0, 0, 0, 0));
`endif

      reset_n = 1'b0;
      req = '0; rel = '0; x = '0;
      #1;
      chk("reset gnt", gnt, 0);
      chk("reset owner", owner, 0);
      chk("reset busy", busy, 0);
      chk("reset cnt", cnt, 0);
      chk("reset done", done, 0);
      chk("reset res_cnt", res_cnt, 0);
      chk("reset res_to", res_to, 0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      foreach (tbl[i]) begin
         req = tbl[i].req;
         rel = tbl[i].rel;
         x   = tbl[i].x;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d gnt", i), gnt, tbl[i].gnt);
         chk($sformatf("v%0d owner", i), owner, tbl[i].own);
         chk($sformatf("v%0d cnt", i), cnt, tbl[i].cnt);
         chk($sformatf("v%0d z_odd", i), z_odd, tbl[i].odd);
         chk($sformatf("v%0d z_sat", i), z_sat, tbl[i].sat);
         chk($sformatf("v%0d done", i), done, tbl[i].done);
         chk($sformatf("v%0d busy", i), busy, tbl[i].busy);
         chk($sformatf("v%0d res_cnt", i), res_cnt, tbl[i].rc);
         chk($sformatf("v%0d res_to", i), res_to, tbl[i].rt);
      end

      // test 6: owner 3 (ptr=2) reaches cnt=2, then async reset mid-cycle
      req = 4'h8; rel = '0; x = '0;
      @(posedge clk);
      #1;
      chk("t6 gnt", gnt, 8);
      chk("t6 owner", owner, 3);
      req = '0;
      x   = 4'h8;
      repeat (2) @(posedge clk);
      #1;
      x = '0;
      chk("t6 cnt", cnt, 2);
      #3;
      reset_n = 1'b0;
      #1;
      chk("t6 rst gnt", gnt, 0);
      chk("t6 rst cnt", cnt, 0);
      chk("t6 rst busy", busy, 0);
      chk("t6 rst owner", owner, 0);
      chk("t6 rst res_cnt", res_cnt, 0);
      @(posedge clk);
      #1;
      chk("t6 rst done", done, 0);
      @(negedge clk);
      reset_n = 1'b1;
      req = 4'hF;
      @(posedge clk);
      #1;
      chk("t6 regrant gnt", gnt, 1);
      chk("t6 regrant owner", owner, 0);
      chk("t6 regrant cnt", cnt, 0);
      req = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
